psram_bus_bridge: RTL
=====================

Name: psram_bus_bridge

Overview:
Converts the CPU6 byte-wide memory bus into request/busy transactions for the PSRAM controller. It sits between the CPU bus and PsramController. It maps the 19-bit CPU byte address into the 22-bit PSRAM space and keeps a one-word (16-bit) read buffer, so a repeated byte read of the same word is served without a PSRAM access. It runs on the PSRAM controller clock; CPU-side requests use a req/ack handshake.

Parameters:
BASE_ADDR, 22'h000000, PSRAM byte offset added to every CPU address.
TIMEOUT, 255, maximum cycles spent in WAIT before the transaction is abandoned (range 1..1023).

Ports:
clock  in  1  bridge and controller clock (81 MHz PSRAM clock)
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  level; held high by the CPU until cpu_ack
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  19  CPU byte address
cpu_wdata  in  8  write byte
cpu_rdata  out  8  read byte; valid in the cpu_ack cycle and held until the next ack
cpu_ack  out  1  single-cycle completion pulse
cpu_err  out  1  sticky timeout flag; cleared only by reset
mem_read  out  1  one-cycle read strobe to the controller
mem_write  out  1  one-cycle write strobe to the controller
mem_byte_write  out  1  qualifies mem_write as a byte write (always 1 with mem_write)
mem_addr  out  22  PSRAM byte address
mem_din  out  16  write data = {cpu_wdata, cpu_wdata}
mem_dout  in  16  read word from the controller
mem_busy  in  1  controller busy; also high during controller init after reset

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer invalid, timeout counter 0.
- Address: eff = (BASE_ADDR + zero-extended cpu_addr) mod 2^22. mem_addr = eff. Word tag = eff[21:1].
- Read lane: cpu_rdata = eff[0] ? word[15:8] : word[7:0].
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE:
  - On cpu_req, the request is latched (we, eff, wdata).
  - Read hit (buffer valid and tag match): go directly to DONE. No mem strobe is issued; total latency from req to ack is 2 cycles.
  - Otherwise: go to ISSUE.
- ISSUE:
  - Waits while mem_busy = 1. This covers controller init after reset.
  - When mem_busy = 0: pulse mem_read or mem_write (with mem_byte_write) for exactly one cycle, then go to GUARD.
- GUARD: one cycle in which mem_busy is ignored, because the controller raises busy one cycle after the strobe. Then go to WAIT.
- WAIT:
  - Counts cycles. When mem_busy = 0, go to DONE.
  - For a read, capture mem_dout into the buffer word, set tag and valid.
  - If the count reaches TIMEOUT first: set cpu_err, invalidate the buffer, set cpu_rdata = 8'hFF, go to DONE.
- DONE:
  - Pulse cpu_ack for one cycle and return to IDLE.
  - A new request is not accepted until cpu_req has been seen low for at least one cycle. The CPU must drop req after ack; a req still high in the cycle after ack is ignored.
- Writes are write-through. If a write tag matches the valid buffer, the addressed byte in the buffer is updated in the WAIT→DONE cycle; the buffer stays valid. A write miss does not allocate.
- mem_addr and mem_din are stable from ISSUE through WAIT. The mem strobes are never asserted outside ISSUE.
- Reset mid-transaction: the FSM returns to IDLE immediately and no ack is produced. The PSRAM controller is reset by the same source at top level.
- cpu_req dropping before ack is a protocol violation. The bridge completes the transaction anyway and still pulses cpu_ack.
- Changes to cpu_addr/cpu_we/cpu_wdata after latching are ignored until DONE.

Test Plan:
- Init gating: reset, hold mem_busy = 1 for 100 cycles, read cpu_addr = 19'h00010 → no mem_read until busy falls. Then mem_read is a single pulse with mem_addr = 22'h000010. Model returns 16'hBEEF → cpu_rdata = 8'hEF with one cpu_ack.
- Read-buffer hit: after the previous read, read 19'h00011 → cpu_ack 2 cycles after req, no mem_read, cpu_rdata = 8'hBE.
- Write-through: write 8'h5A to 19'h00011 → mem_write = mem_byte_write = 1, mem_din = 16'h5A5A, mem_addr = 22'h000011. A following read of 19'h00011 hits with 8'h5A and no mem strobe.
- Base offset and wrap: BASE_ADDR = 22'h3FFFF0, read 19'h00020 → mem_addr = 22'h000010.
- Timeout: model never drops mem_busy, TIMEOUT = 16 → cpu_ack about 19 cycles after the strobe, cpu_rdata = 8'hFF, cpu_err = 1 and stays 1. The next read of the same address issues mem_read, because the buffer was invalidated.
- Reset mid-WAIT: assert reset during WAIT → no cpu_ack, outputs 0. After release, a new read completes normally.

Source files
------------

// File: rtl/psram_bus_bridge.sv
// CPU6 byte bus to PSRAM controller bridge: address mapping, one-word read buffer,
// busy-gated strobes and a WAIT timeout that flags a sticky error.
module psram_bus_bridge #(
    parameter logic [21:0] BASE_ADDR = 22'h000000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_byte_write,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state_q;
    logic        armed_q;
    logic        we_q;
    logic [21:0] addr_q;
    logic [7:0]  wdata_q;
    logic [9:0]  cnt_q;
    logic        to_q;
    logic [15:0] buf_word_q;
    logic [20:0] buf_tag_q;
    logic        buf_valid_q;
    logic [7:0]  rdata_q;
    logic        ack_q;
    logic        err_q;
    logic [21:0] eff_addr;
    logic        buf_match;

    assign eff_addr  = BASE_ADDR + {3'b000, cpu_addr};
    assign buf_match = buf_valid_q && (buf_tag_q == addr_q[21:1]);

    // Strobes follow mem_busy combinationally so they can only ever appear in ISSUE.
    assign mem_read       = (state_q == S_ISSUE) && !mem_busy && !we_q;
    assign mem_write      = (state_q == S_ISSUE) && !mem_busy && we_q;
    assign mem_byte_write = mem_write;
    assign mem_addr       = addr_q;
    assign mem_din        = {wdata_q, wdata_q};
    assign cpu_rdata      = rdata_q;
    assign cpu_ack        = ack_q;
    assign cpu_err        = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            to_q        <= 1'b0;
            buf_word_q  <= '0;
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // A new request needs cpu_req to have been low since the last accept.
            if (!cpu_req) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cpu_req && armed_q) begin
                        armed_q <= 1'b0;
                        we_q    <= cpu_we;
                        addr_q  <= eff_addr;
                        wdata_q <= cpu_wdata;
                        to_q    <= 1'b0;
                        if (!cpu_we && buf_valid_q && (buf_tag_q == eff_addr[21:1])) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!mem_busy) begin
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        if (!we_q) begin
                            buf_word_q  <= mem_dout;
                            buf_tag_q   <= addr_q[21:1];
                            buf_valid_q <= 1'b1;
                        end else if (buf_match) begin
                            if (addr_q[0]) begin
                                buf_word_q[15:8] <= wdata_q;
                            end else begin
                                buf_word_q[7:0] <= wdata_q;
                            end
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_q       <= 1'b1;
                        buf_valid_q <= 1'b0;
                        to_q        <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_DONE: begin
                    ack_q <= 1'b1;
                    if (to_q) begin
                        rdata_q <= 8'hFF;
                    end else if (!we_q) begin
                        rdata_q <= addr_q[0] ? buf_word_q[15:8] : buf_word_q[7:0];
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
